// File: rtl/alu_share_arbiter.sv
// Purpose : round-robin share of one combinational ALU between request ports A and B.
// Latency : request handshake in cycle N -> rsp_valid first high in cycle N+2; one op per 3 cycles peak.
// Backpres: the response is held in RESP until the owner's rsp_ready; no new request is accepted meanwhile.
// Option  : define ALU_ARB_OPCHECK_EN to trap illegal ALU_control codes (result 0, zero 1, rsp_err 1).
module alu_share_arbiter #(
   parameter int WIDTH     = 32,
   parameter int CTRL_W    = 4,
   parameter int PRIO_INIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   // port A
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic [WIDTH-1:0]  a_src1,
   input  logic [WIDTH-1:0]  a_src2,
   input  logic [CTRL_W-1:0] a_ctrl,
   output logic              a_rsp_valid,
   input  logic              a_rsp_ready,
   output logic [WIDTH-1:0]  a_rsp_result,
   output logic              a_rsp_zero,
   // port B
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic [WIDTH-1:0]  b_src1,
   input  logic [WIDTH-1:0]  b_src2,
   input  logic [CTRL_W-1:0] b_ctrl,
   output logic              b_rsp_valid,
   input  logic              b_rsp_ready,
   output logic [WIDTH-1:0]  b_rsp_result,
   output logic              b_rsp_zero,
   // shared ALU
   output logic [WIDTH-1:0]  alu_src1,
   output logic [WIDTH-1:0]  alu_src2,
   output logic [CTRL_W-1:0] alu_ctrl,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic              alu_zero,
   // status
   output logic              busy,
   output logic              grant_id,
   output logic              rsp_err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic PTR_RST = (PRIO_INIT != 0);

   logic [1:0]        state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              grant_q, grant_d;
   logic [WIDTH-1:0]  src1_q, src1_d;
   logic [WIDTH-1:0]  src2_q, src2_d;
   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [WIDTH-1:0]  res_q, res_d;
   logic              zero_q, zero_d;
   logic              bad_q, bad_d;

   logic              take;
   logic              take_b;
   logic [WIDTH-1:0]  req_src1;
   logic [WIDTH-1:0]  req_src2;
   logic [CTRL_W-1:0] req_ctrl;
   logic              in_resp;
   logic              rsp_hs;

`ifdef ALU_ARB_OPCHECK_EN
   function automatic logic ctrl_legal(input logic [CTRL_W-1:0] c);
      logic ok;
      ok = 1'b0;
      if (c == CTRL_W'(4'b0000) || c == CTRL_W'(4'b0001) ||
          c == CTRL_W'(4'b0010) || c == CTRL_W'(4'b0110) ||
          c == CTRL_W'(4'b0111) || c == CTRL_W'(4'b1100))
         ok = 1'b1;
      return ok;
   endfunction
`endif

   // Arbitration: a lone requester wins; on contention the pointer picks. Held off during reset.
   always_comb begin
      take   = 1'b0;
      take_b = 1'b0;
      if (state_q == ST_IDLE && !rst) begin
         if (a_req_valid && b_req_valid) begin
            take   = 1'b1;
            take_b = ptr_q;
         end else if (a_req_valid) begin
            take   = 1'b1;
         end else if (b_req_valid) begin
            take   = 1'b1;
            take_b = 1'b1;
         end
      end
   end

   assign a_req_ready = take & ~take_b;
   assign b_req_ready = take &  take_b;

   assign req_src1 = take_b ? b_src1 : a_src1;
   assign req_src2 = take_b ? b_src2 : a_src2;
   assign req_ctrl = take_b ? b_ctrl : a_ctrl;

   assign in_resp = (state_q == ST_RESP);
   assign rsp_hs  = in_resp && (grant_q ? b_rsp_ready : a_rsp_ready);

   // Next-state logic for the IDLE -> EXEC -> RESP operation cycle.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      src1_d  = src1_q;
      src2_d  = src2_q;
      ctrl_d  = ctrl_q;
      res_d   = res_q;
      zero_d  = zero_q;
      bad_d   = bad_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               grant_d = take_b;
               src1_d  = req_src1;
               src2_d  = req_src2;
               ctrl_d  = req_ctrl;
               bad_d   = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
               // illegal codes are accepted but never reach the ALU
               if (!ctrl_legal(req_ctrl)) begin
                  ctrl_d = '0;
                  bad_d  = 1'b1;
               end
`endif
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            res_d   = bad_q ? '0 : alu_result;
            zero_d  = bad_q ? 1'b1 : alu_zero;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_hs) begin
               ptr_d   = ~grant_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset mid-operation simply drops the operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= PTR_RST;
         grant_q <= 1'b0;
         src1_q  <= '0;
         src2_q  <= '0;
         ctrl_q  <= '0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         src1_q  <= src1_d;
         src2_q  <= src2_d;
         ctrl_q  <= ctrl_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         bad_q   <= bad_d;
      end
   end

   // The ALU sees only the op registers, so its inputs are stable across EXEC and RESP.
   assign alu_src1 = src1_q;
   assign alu_src2 = src2_q;
   assign alu_ctrl = ctrl_q;

   assign a_rsp_valid  = in_resp & ~grant_q;
   assign b_rsp_valid  = in_resp &  grant_q;
   assign a_rsp_result = res_q;
   assign b_rsp_result = res_q;
   assign a_rsp_zero   = zero_q;
   assign b_rsp_zero   = zero_q;

   assign busy     = (state_q != ST_IDLE);
   assign grant_id = grant_q;

`ifdef ALU_ARB_OPCHECK_EN
   assign rsp_err = in_resp & bad_q;
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to the shared port.
// Each scenario task drives stimulus and compares outputs on the falling clock edge.
// Honours ALU_ARB_OPCHECK_EN for the illegal-opcode scenario.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req_valid = 1'b0, b_req_valid = 1'b0;
   logic        a_req_ready, b_req_ready;
   logic [31:0] a_src1 = '0, a_src2 = '0, b_src1 = '0, b_src2 = '0;
   logic [3:0]  a_ctrl = '0, b_ctrl = '0;
   logic        a_rsp_valid, b_rsp_valid;
   logic        a_rsp_ready = 1'b1, b_rsp_ready = 1'b1;
   logic [31:0] a_rsp_result, b_rsp_result;
   logic        a_rsp_zero, b_rsp_zero;
   logic [31:0] alu_src1, alu_src2, alu_result;
   logic [3:0]  alu_ctrl;
   logic        alu_zero;
   logic        busy, grant_id, rsp_err;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_share_arbiter #(.WIDTH(32), .CTRL_W(4), .PRIO_INIT(0)) dut (
      .clk(clk), .rst(rst),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready),
      .a_src1(a_src1), .a_src2(a_src2), .a_ctrl(a_ctrl),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
      .a_rsp_result(a_rsp_result), .a_rsp_zero(a_rsp_zero),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready),
      .b_src1(b_src1), .b_src2(b_src2), .b_ctrl(b_ctrl),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
      .b_rsp_result(b_rsp_result), .b_rsp_zero(b_rsp_zero),
      .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_zero(alu_zero),
      .busy(busy), .grant_id(grant_id), .rsp_err(rsp_err)
   );

   // behavioural ALU; unknown codes produce a recognisable pattern
   always_comb begin
      case (alu_ctrl)
         4'b0000: alu_result = alu_src1 & alu_src2;
         4'b0001: alu_result = alu_src1 | alu_src2;
         4'b0010: alu_result = alu_src1 + alu_src2;
         4'b0110: alu_result = alu_src1 - alu_src2;
         4'b0111: alu_result = {31'b0, ($signed(alu_src1) < $signed(alu_src2))};
         4'b1100: alu_result = ~(alu_src1 | alu_src2);
         default: alu_result = 32'hDEAD_BEEF;
      endcase
   end
   assign alu_zero = (alu_result == 32'h0);

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic do_reset();
      rst = 1'b1;
      a_req_valid = 1'b0; b_req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // present a request on one port; returns cycle of handshake (-1 on timeout), ends at the next negedge
   task automatic issue(input bit port, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [3:0] c, output int hs);
      hs = -1;
      @(negedge clk);
      if (port) begin b_req_valid = 1'b1; b_src1 = s1; b_src2 = s2; b_ctrl = c; end
      else      begin a_req_valid = 1'b1; a_src1 = s1; a_src2 = s2; a_ctrl = c; end
      for (int i = 0; i < 20 && hs < 0; i++) begin
         #1;
         if (port ? b_req_ready : a_req_ready) hs = cyc;
         @(negedge clk);
      end
      if (port) b_req_valid = 1'b0; else a_req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input bit port, output int at);
      at = -1;
      for (int i = 0; i < 20 && at < 0; i++) begin
         if (port ? b_rsp_valid : a_rsp_valid) at = cyc;
         else @(negedge clk);
      end
   endtask

   task automatic run_both(output int hsa, output int hsb, output logic [31:0] ra, output logic [31:0] rb);
      hsa = -1; hsb = -1; ra = '0; rb = '0;
      a_req_valid = 1'b1; a_src1 = 32'hF0; a_src2 = 32'h3C; a_ctrl = 4'b0000;
      b_req_valid = 1'b1; b_src1 = 32'hF0; b_src2 = 32'h0F; b_ctrl = 4'b0001;
      for (int i = 0; i < 14; i++) begin
         #1;
         if (a_req_valid && a_req_ready) hsa = cyc;
         if (b_req_valid && b_req_ready) hsb = cyc;
         if (a_rsp_valid) ra = a_rsp_result;
         if (b_rsp_valid) rb = b_rsp_result;
         @(negedge clk);
         if (hsa >= 0) a_req_valid = 1'b0;
         if (hsb >= 0) b_req_valid = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      tests++;
      if ({busy, grant_id, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_zero, rsp_err} !== 8'h00) begin
         fails++; $display("FAIL reset_flags got=%b want=00000000",
            {busy, grant_id, a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_zero, rsp_err});
      end
      tests++;
      if ({alu_src1, alu_src2, alu_ctrl, a_rsp_result} !== 100'h0) begin
         fails++; $display("FAIL reset_data src1=%h src2=%h ctrl=%b res=%h want all 0", alu_src1, alu_src2, alu_ctrl, a_rsp_result);
      end
      a_req_valid = 1'b1;
      #1;
      tests++;
      if (a_req_ready !== 1'b0) begin
         fails++; $display("FAIL reset_req_ready got=%b want=0", a_req_ready);
      end
      a_req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_a();
      int hs, at;
      issue(1'b0, 32'd5, 32'd7, 4'b0010, hs);
      wait_rsp(1'b0, at);
      tests++;
      if (hs < 0 || at < 0 || at - hs != 2) begin
         fails++; $display("FAIL add_latency got=%0d want=2 (hs=%0d rsp=%0d)", at - hs, hs, at);
      end
      tests++;
      if (a_rsp_result !== 32'd12 || a_rsp_zero !== 1'b0) begin
         fails++; $display("FAIL add_result got=%h/%b want=0000000c/0", a_rsp_result, a_rsp_zero);
      end
      tests++;
      if (b_rsp_valid !== 1'b0 || grant_id !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b1) begin
         fails++; $display("FAIL add_side b_rsp_valid=%b grant=%b err=%b busy=%b want 0/0/0/1", b_rsp_valid, grant_id, rsp_err, busy);
      end
   endtask

   task automatic test_ops_b();
      int hs, at;
      issue(1'b1, 32'h1234, 32'h1234, 4'b0110, hs);
      wait_rsp(1'b1, at);
      tests++;
      if (at < 0 || b_rsp_result !== 32'h0 || b_rsp_zero !== 1'b1 || a_rsp_valid !== 1'b0 || grant_id !== 1'b1) begin
         fails++; $display("FAIL sub_b got=%h/%b a_vld=%b grant=%b want=00000000/1 0 1", b_rsp_result, b_rsp_zero, a_rsp_valid, grant_id);
      end
      issue(1'b1, 32'd3, 32'd9, 4'b0111, hs);
      wait_rsp(1'b1, at);
      tests++;
      if (at < 0 || b_rsp_result !== 32'd1 || b_rsp_zero !== 1'b0) begin
         fails++; $display("FAIL slt_b got=%h/%b want=00000001/0", b_rsp_result, b_rsp_zero);
      end
      issue(1'b1, 32'd0, 32'd0, 4'b1100, hs);
      wait_rsp(1'b1, at);
      tests++;
      if (at < 0 || b_rsp_result !== 32'hFFFF_FFFF) begin
         fails++; $display("FAIL nor_b got=%h want=ffffffff", b_rsp_result);
      end
      @(negedge clk);
   endtask

   task automatic test_contention();
      int hsa, hsb;
      logic [31:0] ra, rb;
      do_reset();
      run_both(hsa, hsb, ra, rb);
      tests++;
      if (hsa < 0 || hsb < 0 || hsb - hsa != 3) begin
         fails++; $display("FAIL both_order a_hs=%0d b_hs=%0d want b_hs=a_hs+3", hsa, hsb);
      end
      tests++;
      if (ra !== 32'h30 || rb !== 32'hFF) begin
         fails++; $display("FAIL both_results a=%h b=%h want 00000030/000000ff", ra, rb);
      end
      run_both(hsa, hsb, ra, rb);
      tests++;
      if (hsa < 0 || hsb < 0 || hsb - hsa != 3 || ra !== 32'h30 || rb !== 32'hFF) begin
         fails++; $display("FAIL both_repeat a_hs=%0d b_hs=%0d a=%h b=%h want A first by 3", hsa, hsb, ra, rb);
      end
   endtask

   task automatic test_backpressure();
      int hs, at;
      a_rsp_ready = 1'b0;
      b_src1 = 32'hFF; b_src2 = 32'h0F; b_ctrl = 4'b0000;
      b_req_valid = 1'b1;
      issue(1'b0, 32'd100, 32'd23, 4'b0010, hs);
      wait_rsp(1'b0, at);
      tests++;
      if (hs < 0 || at < 0) begin
         fails++; $display("FAIL bp_start hs=%0d rsp=%0d want both >=0", hs, at);
      end
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (a_rsp_valid !== 1'b1 || a_rsp_result !== 32'd123 || a_rsp_zero !== 1'b0 ||
             busy !== 1'b1 || b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0) begin
            fails++; $display("FAIL bp_hold[%0d] vld=%b res=%h zero=%b busy=%b b_rdy=%b want 1/0000007b/0/1/0",
               i, a_rsp_valid, a_rsp_result, a_rsp_zero, busy, b_req_ready);
         end
         @(negedge clk);
      end
      a_rsp_ready = 1'b1;
      @(negedge clk);
      #1;
      tests++;
      if (b_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
         fails++; $display("FAIL bp_release b_req_ready=%b a_rsp_valid=%b want 1/0", b_req_ready, a_rsp_valid);
      end
      @(negedge clk);
      b_req_valid = 1'b0;
      wait_rsp(1'b1, at);
      tests++;
      if (at < 0 || b_rsp_result !== 32'h0F) begin
         fails++; $display("FAIL bp_b_result got=%h want=0000000f", b_rsp_result);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int hs, at, hsa, hsb;
      logic [31:0] ra, rb;
      bit seen;
      // one completed A op leaves the pointer on B
      issue(1'b0, 32'd1, 32'd1, 4'b0010, hs);
      wait_rsp(1'b0, at);
      issue(1'b0, 32'h55, 32'h22, 4'b0001, hs);
      tests++;
      if (hs < 0 || busy !== 1'b1 || alu_ctrl !== 4'b0001) begin
         fails++; $display("FAIL mid_exec hs=%0d busy=%b ctrl=%b want busy 1 ctrl 0001", hs, busy, alu_ctrl);
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({busy, grant_id, a_rsp_valid, b_rsp_valid, rsp_err} !== 5'b0 || alu_src1 !== 32'h0 || alu_ctrl !== 4'h0) begin
         fails++; $display("FAIL mid_reset busy=%b grant=%b a_vld=%b src1=%h ctrl=%b want all 0",
            busy, grant_id, a_rsp_valid, alu_src1, alu_ctrl);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (a_rsp_valid || b_rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++; $display("FAIL mid_dropped rsp_valid_seen=%b want=0", seen);
      end
      run_both(hsa, hsb, ra, rb);
      tests++;
      if (hsa < 0 || hsb - hsa != 3 || ra !== 32'h30 || rb !== 32'hFF) begin
         fails++; $display("FAIL mid_fresh a_hs=%0d b_hs=%0d a=%h b=%h want A first", hsa, hsb, ra, rb);
      end
   endtask

   task automatic test_illegal();
      int hs, at;
      issue(1'b0, 32'd6, 32'd7, 4'b1111, hs);
`ifdef ALU_ARB_OPCHECK_EN
      tests++;
      if (hs < 0 || alu_ctrl !== 4'b0000) begin
         fails++; $display("FAIL ill_ctrl got=%b want=0000", alu_ctrl);
      end
      wait_rsp(1'b0, at);
      tests++;
      if (at < 0 || a_rsp_result !== 32'h0 || a_rsp_zero !== 1'b1 || rsp_err !== 1'b1) begin
         fails++; $display("FAIL ill_rsp got=%h/%b err=%b want=00000000/1 err 1", a_rsp_result, a_rsp_zero, rsp_err);
      end
`else
      tests++;
      if (hs < 0 || alu_ctrl !== 4'b1111) begin
         fails++; $display("FAIL ill_ctrl got=%b want=1111", alu_ctrl);
      end
      wait_rsp(1'b0, at);
      tests++;
      if (at < 0 || a_rsp_result !== 32'hDEAD_BEEF || a_rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
         fails++; $display("FAIL ill_rsp got=%h/%b err=%b want=deadbeef/0 err 0", a_rsp_result, a_rsp_zero, rsp_err);
      end
`endif
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add_a();
      test_ops_b();
      test_contention();
      test_backpressure();
      test_reset_mid();
      test_illegal();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
